// File: rtl/postproc_pkg.sv
// Shared definitions for the two-class linear post-process stage: default
// dimensions, the feeder FSM state encoding and the class index type.
package postproc_pkg;

   localparam int N_FEAT    = 288;
   localparam int ITER_W    = 9;
   localparam int DATA_W    = 8;
   localparam int ACC_W     = 32;
   localparam int DRAIN_CYC = 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      READ   = 2'd1,
      DRAIN  = 2'd2,
      RESULT = 2'd3
   } state_t;

   typedef logic class_t;

endpackage

// File: rtl/postproc_argmax2.sv
// Combinational two-way signed argmax; a tie selects index 0 so the lower
// class wins, matching the convention of the multi-class variants.
module postproc_argmax2 #(
   parameter int W = postproc_pkg::ACC_W
) (
   input  logic [W-1:0] score0,
   input  logic [W-1:0] score1,
   output logic         idx
);
   import postproc_pkg::*;

   class_t idx_c;

   assign idx_c = class_t'($signed(score1) > $signed(score0));
   assign idx   = idx_c;

endmodule

// File: rtl/postprocess_linear_feeder.sv
// Streams the flattened feature map into the linear stage, drains it and offers
// the argmax result over valid/ready. Define POSTPROC_FEED_STALL_EN for a stall input.
module postprocess_linear_feeder #(
   parameter int N_FEAT    = postproc_pkg::N_FEAT,
   parameter int ITER_W    = postproc_pkg::ITER_W,
   parameter int DATA_W    = postproc_pkg::DATA_W,
   parameter int ACC_W     = postproc_pkg::ACC_W,
   parameter int DRAIN_CYC = postproc_pkg::DRAIN_CYC
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
`ifdef POSTPROC_FEED_STALL_EN
   input  logic              stall,
`endif
   output logic              busy,
   output logic              done,
   output logic              fm_rd_en,
   output logic [ITER_W-1:0] fm_rd_addr,
   input  logic [DATA_W-1:0] fm_rd_data,
   output logic              lin_en,
   output logic [ITER_W-1:0] lin_iter,
   output logic [DATA_W-1:0] lin_data,
   input  logic [ACC_W-1:0]  lin_out0,
   input  logic [ACC_W-1:0]  lin_out1,
   output logic              res_valid,
   input  logic              res_ready,
   output logic              res_class,
   output logic [ACC_W-1:0]  res_score0,
   output logic [ACC_W-1:0]  res_score1
);
   import postproc_pkg::*;

   localparam logic [ITER_W-1:0] LAST_ADDR  = ITER_W'(N_FEAT - 1);
   localparam logic [ITER_W-1:0] DRAIN_LAST = ITER_W'(DRAIN_CYC);

`ifndef POSTPROC_FEED_STALL_EN
   logic stall;
   assign stall = 1'b0;
`endif

   state_t              state_q, state_d;
   logic [ITER_W-1:0]   cnt_q, cnt_d;
   logic                rd_en;
   logic                capture;
   logic [DATA_W-1:0]   lin_data_q;
   class_t              argmax_idx;

   postproc_argmax2 #(.W(ACC_W)) u_argmax (
      .score0 (lin_out0),
      .score1 (lin_out1),
      .idx    (argmax_idx)
   );

   // NOTE: reset is sampled on the clock edge and all state uses <= so every
   // register updates from the same pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // NOTE: every signal gets a default before the case so no path leaves one
   // unassigned (which would infer a latch).
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rd_en   = 1'b0;
      capture = 1'b0;
      done    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = READ;
               cnt_d   = '0;
            end
         end
         READ: begin
            if (!stall) begin
               rd_en = 1'b1;
               // Compare before incrementing so N_FEAT = 2^ITER_W ends on all-ones.
               if (cnt_q == LAST_ADDR) begin
                  state_d = DRAIN;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         DRAIN: begin
            if (!stall) begin
               if (cnt_q == DRAIN_LAST) begin
                  capture = 1'b1;
                  state_d = RESULT;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         RESULT: begin
            if (res_ready) begin
               done    = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy       = (state_q != IDLE);
   assign res_valid  = (state_q == RESULT);
   assign fm_rd_en   = rd_en;
   assign fm_rd_addr = cnt_q;

   // The buffer returns data one cycle after the strobe, aligned with the
   // registered lin_en, so data passes straight through and is held otherwise.
   assign lin_data = lin_en ? fm_rd_data : lin_data_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         lin_en     <= 1'b0;
         lin_iter   <= '0;
         lin_data_q <= '0;
         res_class  <= 1'b0;
         res_score0 <= '0;
         res_score1 <= '0;
      end else begin
         lin_en <= rd_en;
         if (rd_en) begin
            lin_iter <= cnt_q;
         end
         if (lin_en) begin
            lin_data_q <= fm_rd_data;
         end
         if (capture) begin
            res_class  <= argmax_idx;
            res_score0 <= lin_out0;
            res_score1 <= lin_out1;
         end
      end
   end

endmodule

// File: tb/tb_postprocess_linear_feeder.sv
// Self-checking bench for postprocess_linear_feeder: table of argmax vectors run
// through full inferences, stream/result scoreboards, mid-stream reset sequence.
module tb_postprocess_linear_feeder;
   import postproc_pkg::*;

`ifdef POSTPROC_FEED_STALL_EN
   localparam int STALL_N = 5;
`else
   localparam int STALL_N = 0;
`endif

   typedef struct {
      logic [31:0] o0;
      logic [31:0] o1;
      logic        cls;
      int          hold;
      logic        ready_pre;
      logic        extra_start;
   } vec_t;

   typedef struct {
      logic        cls;
      logic [31:0] s0;
      logic [31:0] s1;
      int          vcyc;
   } exp_res_t;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic              stall = 1'b0;
   logic              busy, done, fm_rd_en, lin_en, res_valid, res_class;
   logic [ITER_W-1:0] fm_rd_addr, lin_iter;
   logic [DATA_W-1:0] fm_rd_data = '0;
   logic [DATA_W-1:0] lin_data;
   logic [ACC_W-1:0]  lin_out0 = '0;
   logic [ACC_W-1:0]  lin_out1 = '0;
   logic              res_ready = 1'b0;
   logic [ACC_W-1:0]  res_score0, res_score1;

   logic [DATA_W-1:0] mem [0:(1<<ITER_W)-1];
   int       n_checks = 0;
   int       n_errors = 0;
   int       cyc = 0;
   int       en_cnt = 0;
   int       first_cyc = -1;
   int       drained_at = -1;
   int       run_start = 0;
   int       mon_e;
   logic [31:0] tgt0 = '0;
   logic [31:0] tgt1 = '0;
   logic [31:0] prev_s0 = '0;
   logic [31:0] prev_s1 = '0;
   int       exp_q[$];
   exp_res_t res_q[$];
   vec_t     vecs[6];

   postprocess_linear_feeder dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
`ifdef POSTPROC_FEED_STALL_EN
      .stall      (stall),
`endif
      .busy       (busy),
      .done       (done),
      .fm_rd_en   (fm_rd_en),
      .fm_rd_addr (fm_rd_addr),
      .fm_rd_data (fm_rd_data),
      .lin_en     (lin_en),
      .lin_iter   (lin_iter),
      .lin_data   (lin_data),
      .lin_out0   (lin_out0),
      .lin_out1   (lin_out1),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_class  (res_class),
      .res_score0 (res_score0),
      .res_score1 (res_score1)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Feature buffer: synchronous read, data one cycle after the strobe.
   always @(posedge clk) begin
      if (fm_rd_en) fm_rd_data <= mem[fm_rd_addr];
   end

   // Linear-stage model: accumulators read as junk until DRAIN_CYC cycles after the last lin_en.
   always @(posedge clk) begin
      #1;
      if (drained_at > run_start && cyc >= drained_at + DRAIN_CYC) begin
         lin_out0 = tgt0;
         lin_out1 = tgt1;
      end else begin
         lin_out0 = tgt0 ^ 32'h5A5A_5A5A;
         lin_out1 = tgt1 ^ 32'hA5A5_A5A5;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Stream scoreboard: each lin_en beat pops the next expected iteration.
   always @(negedge clk) begin
      if (!rst && lin_en) begin
         en_cnt++;
         check("lin_en_expected", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            if (mon_e == 0) first_cyc = cyc;
            check("lin_iter", 64'(lin_iter), 64'(mon_e));
            check("lin_data", 64'(lin_data), 64'(8'(mon_e % 128)));
         end
         if (lin_iter == ITER_W'(N_FEAT - 1)) drained_at = cyc;
      end
   end

   task automatic check_zero(input string tag);
      check({tag, "_busy"},       64'(busy),       64'd0);
      check({tag, "_done"},       64'(done),       64'd0);
      check({tag, "_fm_rd_en"},   64'(fm_rd_en),   64'd0);
      check({tag, "_fm_rd_addr"}, 64'(fm_rd_addr), 64'd0);
      check({tag, "_lin_en"},     64'(lin_en),     64'd0);
      check({tag, "_lin_iter"},   64'(lin_iter),   64'd0);
      check({tag, "_lin_data"},   64'(lin_data),   64'd0);
      check({tag, "_res_valid"},  64'(res_valid),  64'd0);
      check({tag, "_res_class"},  64'(res_class),  64'd0);
      check({tag, "_res_score0"}, 64'(res_score0), 64'd0);
      check({tag, "_res_score1"}, 64'(res_score1), 64'd0);
   endtask

   // Entered and left just after a rising edge, so runs chain back to back.
   task automatic run_vec(input vec_t v);
      int       s;
      int       budget;
      int       base;
      bit       got;
      exp_res_t r;
      tgt0      = v.o0;
      tgt1      = v.o1;
      res_ready = v.ready_pre;
      start     = 1'b1;
      s         = cyc;
      run_start = cyc;
      base      = en_cnt;
      for (int k = 0; k < N_FEAT; k++) exp_q.push_back(k);
      res_q.push_back('{cls: v.cls, s0: v.o0, s1: v.o1,
                        vcyc: s + N_FEAT + 2 + DRAIN_CYC + STALL_N});
      @(negedge clk);
      check("idle_busy",      64'(busy),       64'd0);
      check("idle_res_valid", 64'(res_valid),  64'd0);
      check("idle_done",      64'(done),       64'd0);
      check("held_score0",    64'(res_score0), 64'(prev_s0));
      check("held_score1",    64'(res_score1), 64'(prev_s1));
      @(posedge clk);
      #1 start = 1'b0;
      got    = 1'b0;
      budget = N_FEAT + 100;
      while (!got && budget > 0) begin
         @(negedge clk);
         stall = (STALL_N != 0) && (cyc >= s + 50) && (cyc < s + 50 + STALL_N);
         start = v.extra_start && (cyc == s + 20);
         if (res_valid) got = 1'b1;
         budget--;
      end
      stall = 1'b0;
      start = 1'b0;
      check("res_valid_seen", 64'(res_valid), 64'd1);
      if (!got) begin
         exp_q.delete();
         res_q.delete();
         res_ready = 1'b0;
         @(posedge clk);
         #1;
         return;
      end
      r = res_q.pop_front();
      check("res_valid_cycle", 64'(cyc - s),        64'(r.vcyc - s));
      check("res_class",       64'(res_class),      64'(r.cls));
      check("res_score0",      64'(res_score0),     64'(r.s0));
      check("res_score1",      64'(res_score1),     64'(r.s1));
      check("done_first",      64'(done),           64'(v.ready_pre));
      check("lin_en_count",    64'(en_cnt - base),  64'(N_FEAT));
      check("stream_drained",  64'(exp_q.size()),   64'd0);
      check("first_lin_en",    64'(first_cyc - s),  64'd2);
      check("last_lin_en",     64'(drained_at - s), 64'(N_FEAT + 1 + STALL_N));
      check("lin_iter_hold",   64'(lin_iter),       64'(N_FEAT - 1));
      check("lin_data_hold",   64'(lin_data),       64'((N_FEAT - 1) % 128));
      if (!v.ready_pre) begin
         for (int i = 1; i < v.hold; i++) begin
            @(negedge clk);
            check("stall_res_valid",  64'(res_valid),  64'd1);
            check("stall_done",       64'(done),       64'd0);
            check("stall_res_class",  64'(res_class),  64'(r.cls));
            check("stall_res_score0", 64'(res_score0), 64'(r.s0));
            check("stall_res_score1", 64'(res_score1), 64'(r.s1));
         end
         @(posedge clk);
         #1 res_ready = 1'b1;
         @(negedge clk);
         check("accept_done",      64'(done),      64'd1);
         check("accept_res_valid", 64'(res_valid), 64'd1);
      end
      prev_s0 = v.o0;
      prev_s1 = v.o1;
      @(posedge clk);
      #1 res_ready = 1'b0;
   endtask

   task automatic reset_mid();
      int budget;
      bit got;
      tgt0      = 32'd1;
      tgt1      = 32'd2;
      start     = 1'b1;
      run_start = cyc;
      for (int k = 0; k < N_FEAT; k++) exp_q.push_back(k);
      @(posedge clk);
      #1 start = 1'b0;
      got    = 1'b0;
      budget = 200;
      while (!got && budget > 0) begin
         @(negedge clk);
         if (lin_en && lin_iter == ITER_W'(100)) got = 1'b1;
         budget--;
      end
      check("reset_reach_iter100", 64'(lin_iter), 64'd100);
      rst = 1'b1;
      @(negedge clk);
      check_zero("mid_reset");
      @(posedge clk);
      #1 rst = 1'b0;
      exp_q.delete();
      prev_s0 = '0;
      prev_s1 = '0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int k = 0; k < (1 << ITER_W); k++) mem[k] = 8'(k % 128);
      vecs[0] = '{o0: 32'hFFFF_FFFB, o1: 32'd7,         cls: 1'b1, hold: 10, ready_pre: 1'b0, extra_start: 1'b1};
      vecs[1] = '{o0: 32'h7FFF_FFFF, o1: 32'h7FFF_FFFF, cls: 1'b0, hold: 0,  ready_pre: 1'b1, extra_start: 1'b0};
      vecs[2] = '{o0: 32'h8000_0000, o1: 32'hFFFF_FFFF, cls: 1'b1, hold: 3,  ready_pre: 1'b0, extra_start: 1'b0};
      vecs[3] = '{o0: 32'h0000_0000, o1: 32'hFFFF_FFFF, cls: 1'b0, hold: 0,  ready_pre: 1'b1, extra_start: 1'b0};
      vecs[4] = '{o0: 32'd100,       o1: 32'd99,        cls: 1'b0, hold: 1,  ready_pre: 1'b0, extra_start: 1'b0};
      vecs[5] = '{o0: 32'h8000_0000, o1: 32'h8000_0000, cls: 1'b0, hold: 0,  ready_pre: 1'b1, extra_start: 1'b0};

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_zero("reset");
      @(posedge clk);
      #1 rst = 1'b0;

      for (int i = 0; i < 3; i++) run_vec(vecs[i]);
      reset_mid();
      for (int i = 3; i < 6; i++) run_vec(vecs[i]);

      @(negedge clk);
      check("tail_busy",      64'(busy),       64'd0);
      check("tail_res_valid", 64'(res_valid),  64'd0);
      check("tail_done",      64'(done),       64'd0);
      check("tail_score0",    64'(res_score0), 64'(prev_s0));
      check("tail_score1",    64'(res_score1), 64'(prev_s1));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/postprocess_linear_feeder.md
Name: postprocess_linear_feeder

Overview:
Sequencer on the upstream end of the two-class linear post-process stage. On `start` it streams the flattened feature map from the feature buffer into the linear stage as `en`/`iter`/`data`, one feature per cycle. After the last feature it drains the linear pipeline and captures both 32-bit class accumulators. It then presents an argmax decision over a valid/ready handshake to the result/output logic.

Parameters:
- N_FEAT, 288, features per inference; must satisfy 1 <= N_FEAT <= 2^ITER_W
- ITER_W, 9, width of the iteration index
- DATA_W, 8, signed feature width
- ACC_W, 32, signed accumulator width of the linear stage
- DRAIN_CYC, 2, cycles from the last `lin_en` until `lin_out0`/`lin_out1` are final

Ports:
- clk  in  1  clock
- rst  in  1  reset
- start  in  1  one-cycle request to begin an inference; honoured only in IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on the cycle the result handshake completes
- fm_rd_en  out  1  feature buffer read strobe
- fm_rd_addr  out  ITER_W  feature buffer address
- fm_rd_data  in  DATA_W  signed read data, valid 1 cycle after `fm_rd_en`
- lin_en  out  1  linear stage enable
- lin_iter  out  ITER_W  iteration index to the linear stage
- lin_data  out  DATA_W  signed feature to the linear stage
- lin_out0  in  ACC_W  signed class-0 accumulator
- lin_out1  in  ACC_W  signed class-1 accumulator
- res_valid  out  1  result valid
- res_ready  in  1  result accept
- res_class  out  1  argmax index
- res_score0  out  ACC_W  captured class-0 score
- res_score1  out  ACC_W  captured class-1 score

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset state: all outputs 0; FSM in IDLE.
- Reset priority: `rst` overrides everything, including mid-stream and during RESULT. The FSM returns to IDLE and any partial result is discarded.
- FSM states: IDLE, READ, DRAIN, RESULT.
- IDLE:
  - On `start`: go to READ with the address counter at 0.
  - `start` in any other state is ignored.
- READ (read issue):
  - `fm_rd_en` = 1 and `fm_rd_addr` = counter; counter increments each cycle.
  - After issuing address N_FEAT-1, go to DRAIN.
- Linear drive:
  - Registered one cycle behind the read issue: `lin_en` = 1, `lin_iter` = the address issued in the previous cycle, `lin_data` = `fm_rd_data`.
  - Exactly N_FEAT `lin_en` cycles per inference, with `lin_iter` = 0..N_FEAT-1 in order and no gaps.
  - `lin_iter`/`lin_data` hold their last values when `lin_en` = 0.
- DRAIN:
  - The counter counts DRAIN_CYC cycles after the last `lin_en` cycle.
  - Then capture `res_score0` = `lin_out0` and `res_score1` = `lin_out1`.
  - Set `res_class` = (signed `lin_out1` > signed `lin_out0`); a tie gives class 0.
  - Assert `res_valid` and go to RESULT.
- RESULT:
  - `res_valid` and all `res_*` values are held stable until `res_ready`.
  - On the cycle `res_valid` && `res_ready`: `done` = 1; next cycle `res_valid` = 0 and the FSM is in IDLE.
  - `res_ready` already high when `res_valid` rises: the handshake completes on that first cycle, giving a 1-cycle RESULT.
  - `res_score*` keep their values after the handshake until the next capture.
- Latency: `start` at cycle 0 gives the first `lin_en` at cycle 2, the last `lin_en` at cycle N_FEAT+1, and `res_valid` at cycle N_FEAT+2+DRAIN_CYC.
- Counter boundary: the counter is ITER_W bits. N_FEAT = 2^ITER_W must terminate on the all-ones address with no wrap-around issue.
- Back-to-back inferences: `start` on the cycle after `done` is accepted.

Optional Feature:
- Macro: POSTPROC_FEED_STALL_EN
- Defined: adds input port `stall` (1 bit).
  - While `stall` = 1, READ issues no read and the counter holds.
  - The linear-drive stage emits `lin_en` = 0 for the corresponding cycle, so every issued read still yields exactly one `lin_en`.
  - The DRAIN counter freezes.
  - RESULT is unaffected.
- Not defined: no `stall` port; the stream is gap-free as specified above.

Decomposition:
- Package `postproc_pkg` holds:
  - N_FEAT, ITER_W, DATA_W, ACC_W, DRAIN_CYC defaults;
  - the FSM state enum (IDLE, READ, DRAIN, RESULT);
  - a `class_t` 1-bit typedef.
- One natural sub-module, `postproc_argmax2`: combinational signed compare of two ACC_W values returning the index, with a tie giving 0. It is reused by later multi-class variants.

Test Plan:
- Buffer preloaded with feature k = k mod 128, N_FEAT = 288, `start` pulse -> `lin_en` high for exactly 288 consecutive cycles starting 2 cycles after `start`, `lin_iter` 0..287, `lin_data` = `lin_iter` mod 128.
- Model drives `lin_out0` = -5, `lin_out1` = 7 at capture -> `res_class` = 1, `res_score0` = -5, `res_score1` = 7, `res_valid` at cycle 292 with DRAIN_CYC = 2.
- Tie case `lin_out0` = `lin_out1` = 0x7FFFFFFF -> `res_class` = 0. Case `lin_out0` = 0x80000000, `lin_out1` = -1 -> `res_class` = 1.
- `res_ready` held low 10 cycles -> `res_valid` and scores stable for all 10 cycles; `done` pulses once on acceptance; `busy` drops the next cycle; a second `start` mid-stream is ignored.
- `rst` asserted at `lin_iter` = 100 -> next cycle all outputs 0 and the FSM in IDLE; a new `start` restarts at `lin_iter` = 0.
- POSTPROC_FEED_STALL_EN defined, `stall` high for 5 cycles mid-stream -> still exactly 288 `lin_en` cycles in order, and `res_valid` delayed by 5 cycles.
